// File: rtl/ma_hysteresis_detector.sv
`default_nettype none
// ============================================================================
// Module   : ma_hysteresis_detector
// Purpose  : Threshold detector with hysteresis and debounce for the averaged
//            sample stream of the moving-average filter. Emits a level flag and
//            one-cycle rise/fall event pulses. Optionally tracks the peak
//            average seen during each active episode.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_WIDTH : width of samples and thresholds (unsigned)
//   DEBOUNCE   : consecutive qualifying valid samples needed to change state
//                (must be >= 1)
// Ports
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   valid_in   : sample qualifier; only valid cycles advance state/counter
//   data_in    : averaged sample
//   thr_high   : assert threshold   (qualifies when data_in >= thr_high)
//   thr_low    : release threshold  (qualifies when data_in <= thr_low)
//   level_out  : 1 while in ACTIVE or RELEASING
//   rise_pulse : one-cycle pulse on entry to ACTIVE
//   fall_pulse : one-cycle pulse on return to IDLE
//   peak_out   : max sample of current/last episode (0 without peak hold)
//   peak_valid : one-cycle pulse coincident with fall_pulse (0 without peak hold)
// Configuration macro
//   PEAK_HOLD_EN : when defined, builds the peak-tracking register. When
//                  undefined, peak_out and peak_valid are tied to 0.
// ============================================================================
module ma_hysteresis_detector #(
  parameter int DATA_WIDTH = 16,
  parameter int DEBOUNCE   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] thr_high,
  input  logic [DATA_WIDTH-1:0] thr_low,
  output logic                  level_out,
  output logic                  rise_pulse,
  output logic                  fall_pulse,
  output logic [DATA_WIDTH-1:0] peak_out,
  output logic                  peak_valid
);

  // Guard keeps widths legal while the elaboration error below fires.
  localparam int CNT_W = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);

  // Counter compare is done one bit wider so cnt+1 never wraps.
  localparam logic [CNT_W:0] C_DEBOUNCE = (CNT_W + 1)'(DEBOUNCE);
  localparam logic [CNT_W:0] C_ONE      = (CNT_W + 1)'(1);

  if (DEBOUNCE < 1) begin : g_bad_debounce
    $error("ma_hysteresis_detector: DEBOUNCE must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ARMING    = 2'd1,
    S_ACTIVE    = 2'd2,
    S_RELEASING = 2'd3
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             rise_q;
  logic             fall_q;

  logic             w_hi_qual;
  logic             w_lo_qual;
  logic [CNT_W:0]   w_cnt_inc;
  logic             w_cnt_done;
  logic             w_in_episode;
  logic             w_enter_active;
  logic             w_exit_active;

  assign w_hi_qual  = (data_in >= thr_high);
  assign w_lo_qual  = (data_in <= thr_low);
  assign w_cnt_inc  = {1'b0, cnt_q} + C_ONE;
  assign w_cnt_done = (w_cnt_inc == C_DEBOUNCE);

  assign w_in_episode = (state_q == S_ACTIVE) || (state_q == S_RELEASING);

  // Episode boundary events on the accepting valid sample.
  assign w_enter_active = valid_in && !w_in_episode && w_hi_qual && w_cnt_done;
  assign w_exit_active  = valid_in &&  w_in_episode && w_lo_qual && w_cnt_done;

  // IDLE and ARMING share one rule set: IDLE always holds cnt == 0, so the
  // first qualifying sample yields cnt+1 == 1, which also covers DEBOUNCE == 1
  // (straight to ACTIVE). ACTIVE/RELEASING mirror this for the release side.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      // Pulses last exactly one cycle, including across valid_in gaps.
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (valid_in) begin
        case (state_q)
          S_IDLE, S_ARMING: begin
            if (w_hi_qual) begin
              if (w_cnt_done) begin
                state_q <= S_ACTIVE;
                cnt_q   <= '0;
                level_q <= 1'b1;
                rise_q  <= 1'b1;
              end else begin
                state_q <= S_ARMING;
                cnt_q   <= w_cnt_inc[CNT_W-1:0];
              end
            end else begin
              state_q <= S_IDLE;
              cnt_q   <= '0;
            end
          end
          S_ACTIVE, S_RELEASING: begin
            if (w_lo_qual) begin
              if (w_cnt_done) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                level_q <= 1'b0;
                fall_q  <= 1'b1;
              end else begin
                state_q <= S_RELEASING;
                cnt_q   <= w_cnt_inc[CNT_W-1:0];
              end
            end else begin
              state_q <= S_ACTIVE;
              cnt_q   <= '0;
            end
          end
          default: begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign level_out  = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

`ifdef PEAK_HOLD_EN
  logic [DATA_WIDTH-1:0] peak_q;
  logic                  peak_valid_q;

  // The peak restarts only on a fresh episode (entry from IDLE/ARMING); a
  // bounce from RELEASING back to ACTIVE keeps accumulating the maximum.
  always_ff @(posedge clk) begin
    if (rst) begin
      peak_q       <= '0;
      peak_valid_q <= 1'b0;
    end else begin
      peak_valid_q <= w_exit_active;
      if (w_enter_active) begin
        peak_q <= data_in;
      end else if (valid_in && w_in_episode && (data_in > peak_q)) begin
        peak_q <= data_in;
      end
    end
  end

  assign peak_out   = peak_q;
  assign peak_valid = peak_valid_q;
`else
  assign peak_out   = '0;
  assign peak_valid = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ma_hysteresis_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_ma_hysteresis_detector
// Purpose  : Self-checking bench for ma_hysteresis_detector. A behavioural
//            model (level flag + streak counter) predicts every output each
//            cycle; directed scenarios add literal expectations, followed by
//            randomized valid/data/threshold/reset traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ma_hysteresis_detector;

  localparam int DW  = 16;
  localparam int DEB = 3;

  logic          clk;
  logic          rst;
  logic          valid_in;
  logic [DW-1:0] data_in;
  logic [DW-1:0] thr_high;
  logic [DW-1:0] thr_low;
  logic          level_out;
  logic          rise_pulse;
  logic          fall_pulse;
  logic [DW-1:0] peak_out;
  logic          peak_valid;

  int n_checks = 0;
  int n_errors = 0;

  ma_hysteresis_detector #(
    .DATA_WIDTH (DW),
    .DEBOUNCE   (DEB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .thr_high   (thr_high),
    .thr_low    (thr_low),
    .level_out  (level_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .peak_out   (peak_out),
    .peak_valid (peak_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ------------------------------------------------------------------
  // Behavioural model: "are we in an episode" plus how many consecutive
  // qualifying samples have been seen toward the opposite condition.
  // ------------------------------------------------------------------
  bit          m_started = 1'b0;
  bit          m_level   = 1'b0;
  int          m_streak  = 0;
  int unsigned m_peak    = 0;
  bit          e_rise    = 1'b0;
  bit          e_fall    = 1'b0;
  bit          e_pv      = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_started = 1'b1;
      m_level   = 1'b0;
      m_streak  = 0;
      m_peak    = 0;
      e_rise    = 1'b0;
      e_fall    = 1'b0;
      e_pv      = 1'b0;
    end else begin
      e_rise = 1'b0;
      e_fall = 1'b0;
      e_pv   = 1'b0;
      if (valid_in) begin
        if (!m_level) begin
          if (int'(data_in) >= int'(thr_high)) begin
            m_streak = m_streak + 1;
            if (m_streak == DEB) begin
              m_level  = 1'b1;
              m_streak = 0;
              e_rise   = 1'b1;
              m_peak   = data_in;
            end
          end else begin
            m_streak = 0;
          end
        end else begin
          if (data_in > m_peak) m_peak = data_in;
          if (int'(data_in) <= int'(thr_low)) begin
            m_streak = m_streak + 1;
            if (m_streak == DEB) begin
              m_level  = 1'b0;
              m_streak = 0;
              e_fall   = 1'b1;
              e_pv     = 1'b1;
            end
          end else begin
            m_streak = 0;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_started) begin
      chk("model_level", level_out,  m_level);
      chk("model_rise",  rise_pulse, e_rise);
      chk("model_fall",  fall_pulse, e_fall);
`ifdef PEAK_HOLD_EN
      chk("model_peak",  peak_out,   m_peak);
      chk("model_pv",    peak_valid, e_pv);
`else
      chk("model_peak",  peak_out,   0);
      chk("model_pv",    peak_valid, 0);
`endif
    end
  end

  // Apply one cycle of input and return just after the edge.
  task automatic step(input logic v, input int unsigned d);
    valid_in = v;
    data_in  = DW'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int unsigned d0, input int unsigned d1, input int unsigned d2);
    step(1'b1, d0);
    step(1'b1, d1);
    step(1'b1, d2);
  endtask

  initial begin
    rst      = 1'b1;
    valid_in = 1'b1;
    data_in  = 16'd200;
    thr_high = 16'd100;
    thr_low  = 16'd50;

    // 1: reset dominates valid qualifying data
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 200);
      chk("rst_level", level_out, 0);
      chk("rst_rise",  rise_pulse, 0);
      chk("rst_peak",  peak_out, 0);
    end
    rst = 1'b0;

    // 2: basic rise
    step(1'b1, 120);
    step(1'b1, 130);
    chk("pre_rise", rise_pulse, 0);
    step(1'b1, 140);
    chk("rise_140", rise_pulse, 1);
    chk("level_140", level_out, 1);
    step(1'b0, 0);
    chk("rise_one_cycle", rise_pulse, 0);
    chk("level_hold", level_out, 1);

    // back to idle
    feed(50, 40, 30);
    chk("fall_basic", fall_pulse, 1);

    // 3: broken streak
    feed(120, 130, 90);
    step(1'b1, 120);
    step(1'b1, 130);
    chk("no_rise_broken", rise_pulse, 0);
    chk("no_level_broken", level_out, 0);
    step(1'b1, 140);
    chk("rise_after_broken", rise_pulse, 1);

    // 4: exact-threshold boundaries
    feed(40, 40, 40);
    feed(100, 100, 100);
    chk("rise_boundary", rise_pulse, 1);
    feed(50, 50, 50);
    chk("fall_boundary", fall_pulse, 1);
    chk("level_boundary", level_out, 0);

    // 5: gaps hold the counter
    step(1'b1, 120);
    for (int i = 0; i < 5; i++) step(1'b0, 0);
    step(1'b1, 130);
    chk("gap_no_rise", rise_pulse, 0);
    step(1'b1, 140);
    chk("gap_rise", rise_pulse, 1);

    // 6: peak of an episode, then reset while releasing
    step(1'b1, 160);
    feed(40, 30, 20);
    chk("peak_fall", fall_pulse, 1);
`ifdef PEAK_HOLD_EN
    chk("peak_valid_lit", peak_valid, 1);
    chk("peak_160", peak_out, 160);
`endif
    feed(120, 130, 140);
    step(1'b1, 40);
    step(1'b1, 30);
    rst = 1'b1;
    step(1'b1, 20);
    rst = 1'b0;
    chk("rst_mid_level", level_out, 0);
    chk("rst_mid_fall",  fall_pulse, 0);
    chk("rst_mid_peak",  peak_out, 0);
    chk("rst_mid_pv",    peak_valid, 0);

    // Randomized traffic, with occasional threshold changes and resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 3) begin
        thr_high = DW'($urandom_range(20, 180));
        thr_low  = DW'($urandom_range(10, 190));
      end else if ($urandom_range(0, 199) == 0) begin
        thr_high = 16'd100;
        thr_low  = 16'd50;
      end
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 9) == 0)
        step(1'b1, $urandom_range(0, 65535));
      else
        step($urandom_range(0, 3) != 0, $urandom_range(0, 200));
    end
    rst = 1'b0;
    step(1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
